sequential_alu: RTL and testbench
=================================

Name: sequential_alu

Overview:
- Parametrised, registered successor to the combinational N-bit ALU in the NanoProcessor datapath.
- Extends the opcode set to 8 operations, adds registered status flags (Z/N/C/V), and adds an iterative shift-add multiplier with a start/busy/done handshake.
- Sits between the register file read ports and the write-back mux.
- The control unit issues `start` and waits for `done` before writing back `result` and `flags`.

Parameters:
- N, 4, operand/result width in bits; N ≥ 2.
- SW, $clog2(N), shift-amount width (derived; not overridden).

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  operation request; sampled only while busy=0.
- operation_code  input  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 shl, 110 shr (logical), 111 mul.
- A  input  N  operand A.
- B  input  N  operand B. For shifts, B[SW-1:0] is the shift amount.
- result  output  N  registered result.
- flags  output  4  registered {Z, Neg, C, V}.
- busy  output  1  high while a multiply is in progress.
- done  output  1  one-cycle pulse: result and flags are valid and updated.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-high.
  - Reset values: result=0, flags=0, busy=0, done=0, FSM=IDLE, internal accumulator/counter=0.
- FSM states: IDLE, MUL.
- IDLE:
  - start=1 with a non-mul opcode: at that edge, compute from A/B/opcode and register result and flags; done=1 for the next cycle only.
  - Latency 1. busy never rises. Back-to-back starts are allowed every cycle.
  - start=1 with opcode 111: at that edge, latch mcand=A and mplier=B; set acc=0, cnt=0, busy=1; go to MUL. result and flags are held.
  - start=0: outputs hold; done=0.
- MUL (each edge):
  - If mplier[0], acc = acc + mcand (mod 2^N).
  - Then mcand <<= 1, mplier >>= 1, cnt++.
  - On the edge where cnt==N-1: register result = the updated acc and the flags; busy=0, done=1; return to IDLE.
  - done is therefore high in cycle N after the start edge.
  - start, A, B and operation_code are ignored while busy=1; operands are captured at start.
- Arithmetic (all modulo 2^N):
  - add: {C,result} = A+B.
  - sub: {C,result} = A + ~B + 1. C=1 means no borrow.
  - V (add/sub): signed overflow. add: A[N-1]==B[N-1] && result[N-1]!=A[N-1]. sub: A[N-1]!=B[N-1] && result[N-1]!=A[N-1].
  - and/or/xor: C=0, V=0.
  - shl by s: C = A[N-s] (last bit shifted out); C=0 when s=0. V=0.
  - shr by s: C = A[s-1]; C=0 when s=0. V=0. Zero fill.
  - mul: result is the low N bits of the unsigned product. C=0, V=0.
  - All ops: Z = (result==0), Neg = result[N-1].
- Boundary conditions:
  - Reset asserted mid-multiply: aborts immediately to the reset state; no done pulse; result returns to 0.
  - Multiply by 0 still takes N cycles.
  - Shift amount is limited by SW bits. For non-power-of-2 N, amounts ≥ N give result 0, C=0.
  - done and start in the same cycle in IDLE: the new operation is accepted, and done is reasserted the following cycle for the new result.

Test Plan:
- N=4, reset released. add A=0111, B=1001 -> next cycle result=0000, flags Z=1 Neg=0 C=1 V=0, done=1 for exactly 1 cycle, busy=0.
- add A=0111, B=0001 -> result=1000, Z=0 Neg=1 C=0 V=1. Then sub A=0011, B=0101 -> result=1110, Neg=1 C=0 V=0.
- shl A=1011, B=0001 -> result=0110, C=1. shr A=1011, B=0010 -> result=0010, C=1. shl with B=0000 -> result=1011, C=0.
- mul A=0011, B=0101 with start held 1 cycle -> busy=1 for 4 cycles, done in cycle 4, result=1111. Meanwhile, start with add A=0001, B=0001 at cycle 2 is ignored (result stays 1111, no extra done).
- mul A=0110, B=0110 -> result=0100 (36 mod 16), C=0, V=0. mul A=1111, B=0000 -> result=0000, Z=1 after 4 cycles.
- mul started, reset pulsed at cycle 2 -> busy=0, result=0, flags=0 immediately; no done pulse. A new add after reset completes normally in 1 cycle.

Source files
------------

// File: rtl/sequential_alu.sv
// Registered N-bit ALU with Z/N/C/V flags and an iterative shift-add multiplier.
// Latency: 1 cycle for add/sub/logic/shift ops, N cycles for mul (done pulses once).
// Backpressure: start is ignored while busy=1; non-mul ops may be issued every cycle.
module sequential_alu #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   operation_code,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic [N-1:0] result,
  output logic [3:0]   flags,
  output logic         busy,
  output logic         done
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {IDLE, MUL} state_t;

  state_t        state;
  logic [N-1:0]  mcand;
  logic [N-1:0]  mplier;
  logic [N-1:0]  acc;
  logic [SW-1:0] cnt;

  logic [N-1:0]  alu_res;
  logic          alu_c;
  logic          alu_v;
  logic [N:0]    wide;
  logic [SW-1:0] sh;
  logic [N-1:0]  acc_next;

  always_comb begin
    sh      = B[SW-1:0];
    wide    = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (operation_code)
      OP_ADD: begin
        wide    = {1'b0, A} + {1'b0, B};
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (A[N-1] == B[N-1]) && (alu_res[N-1] != A[N-1]);
      end
      OP_SUB: begin
        wide    = {1'b0, A} + {1'b0, ~B} + (N+1)'(1);
        alu_res = wide[N-1:0];
        alu_c   = wide[N];
        alu_v   = (A[N-1] != B[N-1]) && (alu_res[N-1] != A[N-1]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SHL: begin
        // The extra top bit catches the last bit shifted out.
        wide = {1'b0, A} << sh;
        if (int'(sh) < N) begin
          alu_res = wide[N-1:0];
          alu_c   = wide[N];
        end
      end
      OP_SHR: begin
        wide = {A, 1'b0} >> sh;
        if (int'(sh) < N) begin
          alu_res = wide[N:1];
          alu_c   = wide[0];
        end
      end
      default: ;
    endcase
  end

  assign acc_next = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      result <= '0;
      flags  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (operation_code == OP_MUL) begin
              mcand  <= A;
              mplier <= B;
              acc    <= '0;
              cnt    <= '0;
              busy   <= 1'b1;
              state  <= MUL;
            end else begin
              result <= alu_res;
              flags  <= {alu_res == '0, alu_res[N-1], alu_c, alu_v};
              done   <= 1'b1;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + SW'(1);
          if (cnt == SW'(N-1)) begin
            result <= acc_next;
            flags  <= {acc_next == '0, acc_next[N-1], 2'b00};
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_alu.sv
// Randomized self-checking bench for sequential_alu against an arithmetic reference model.
module tb_sequential_alu;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [2:0]   operation_code;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [N-1:0] result;
  logic [3:0]   flags;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  sequential_alu #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .operation_code(operation_code),
    .A(A), .B(B), .result(result), .flags(flags), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Returns {flags, result}, derived from integer arithmetic on the operands.
  function automatic logic [7:0] model(input int op, input int a, input int b);
    int r, s, sa, sb, t;
    bit c, v;
    logic [3:0] f;
    c = 0; v = 0; r = 0;
    s = b % 4;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    case (op)
      0: begin r = (a + b) % 16; c = (a + b) >= 16; t = sa + sb; v = (t > 7) || (t < -8); end
      1: begin r = (a - b + 16) % 16; c = (a >= b); t = sa - sb; v = (t > 7) || (t < -8); end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: begin t = a * (1 << s); r = t % 16; c = (s > 0) && (((t / 16) % 2) == 1); end
      6: begin r = a / (1 << s); c = (s > 0) && (((a / (1 << (s - 1))) % 2) == 1); end
      default: r = (a * b) % 16;
    endcase
    f = {r == 0, r >= 8, c, v};
    return {f, 4'(r)};
  endfunction

  task automatic single(input int op, input int a, input int b);
    logic [7:0] e;
    e = model(op, a, b);
    @(negedge clk);
    start = 1'b1; operation_code = 3'(op); A = 4'(a); B = 4'(b);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("op%0d_done a=%0h b=%0h", op, a, b), 32'(done), 32'd1);
    check($sformatf("op%0d_busy", op), 32'(busy), 32'd0);
    check($sformatf("op%0d_result a=%0h b=%0h", op, a, b), 32'(result), 32'(e[3:0]));
    check($sformatf("op%0d_flags a=%0h b=%0h", op, a, b), 32'(flags), 32'(e[7:4]));
    @(negedge clk);
    check($sformatf("op%0d_done_drop", op), 32'(done), 32'd0);
    check($sformatf("op%0d_hold", op), 32'(result), 32'(e[3:0]));
  endtask

  task automatic mul_run(input int a, input int b, input bit inject);
    logic [7:0] e;
    int done_at, busy_n, done_n;
    logic [3:0] got_r, got_f;
    e = model(7, a, b);
    done_at = -1; busy_n = 0; done_n = 0; got_r = 'x; got_f = 'x;
    @(negedge clk);
    start = 1'b1; operation_code = 3'b111; A = 4'(a); B = 4'(b);
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) begin done_at = k; got_r = result; got_f = flags; end
      end
      if (k == 0) start = 1'b0;
      if (inject && k == 2) begin start = 1'b1; operation_code = 3'b000; A = 4'd1; B = 4'd1; end
      if (inject && k == 3) start = 1'b0;
    end
    check($sformatf("mul_done_cycle a=%0h b=%0h", a, b), 32'(done_at), 32'(N));
    check("mul_busy_cycles", 32'(busy_n), 32'(N));
    check("mul_done_pulses", 32'(done_n), 32'd1);
    check($sformatf("mul_result a=%0h b=%0h", a, b), 32'(got_r), 32'(e[3:0]));
    check($sformatf("mul_flags a=%0h b=%0h", a, b), 32'(got_f), 32'(e[7:4]));
    check("mul_result_hold", 32'(result), 32'(e[3:0]));
  endtask

  task automatic burst(input int m);
    logic [7:0] e;
    int op, a, b;
    op = $urandom_range(0, 6); a = $urandom_range(0, 15); b = $urandom_range(0, 15);
    @(negedge clk);
    start = 1'b1; operation_code = 3'(op); A = 4'(a); B = 4'(b);
    e = model(op, a, b);
    for (int i = 0; i < m; i++) begin
      @(negedge clk);
      check("burst_done", 32'(done), 32'd1);
      check($sformatf("burst_result op%0d a=%0h b=%0h", op, a, b), 32'(result), 32'(e[3:0]));
      check($sformatf("burst_flags op%0d a=%0h b=%0h", op, a, b), 32'(flags), 32'(e[7:4]));
      op = $urandom_range(0, 6); a = $urandom_range(0, 15); b = $urandom_range(0, 15);
      operation_code = 3'(op); A = 4'(a); B = 4'(b);
      e = model(op, a, b);
      if (i == m - 1) start = 1'b0;
    end
  endtask

  initial begin
    int done_n;
    reset = 1'b1; start = 1'b0; operation_code = '0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    reset = 1'b0;

    single(0, 4'b0111, 4'b1001);
    single(0, 4'b0111, 4'b0001);
    single(1, 4'b0011, 4'b0101);
    single(5, 4'b1011, 4'b0001);
    single(6, 4'b1011, 4'b0010);
    single(5, 4'b1011, 4'b0000);
    mul_run(4'b0011, 4'b0101, 1'b1);
    mul_run(4'b0110, 4'b0110, 1'b0);
    mul_run(4'b1111, 4'b0000, 1'b0);

    // Abort a multiply with reset after a nonzero result is on the outputs.
    single(2, 4'b1111, 4'b1010);
    @(negedge clk);
    start = 1'b1; operation_code = 3'b111; A = 4'd3; B = 4'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_result", 32'(result), 32'd0);
    check("abort_flags", 32'(flags), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_n = 0;
    repeat (N + 2) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", 32'(done_n), 32'd0);
    single(0, 4'b0010, 4'b0011);

    for (int i = 0; i < 30; i++) begin
      int op;
      op = $urandom_range(0, 7);
      if (op == 7) mul_run($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
      else single(op, $urandom_range(0, 15), $urandom_range(0, 15));
    end

    burst(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
